// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_pkg
// Brief   : Shared types and constants for the instruction-fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } ifu_state_t;

  // Sticky fault codes reported on o_fault_code
  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUSERR   = 2'd2;
  localparam logic [1:0] FAULT_RANGE    = 2'd3;

  // Default architectural PC after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch
// Brief   : Non-speculative instruction-fetch stage. Owns the PC, issues one
//           imem request per instruction, hands the word to decode and loads
//           the next PC when the instruction retires from fetch.
// Revision: 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_4,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_fault,
  output logic [1:0]  o_fault_code
);

  // End of the legal fetch window, one bit wider so the sum cannot wrap
  localparam logic [32:0] c_WIN_END = {1'b0, RESET_PC} + {1'b0, IMEM_BYTES};

  ifu_state_t  r_state;
  ifu_state_t  w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [1:0]  r_fault_code;

  logic        w_in_range;
  logic        w_imem_req;
  logic        w_retire;
  logic        w_misaligned;
  logic        w_resp_ok;
  logic        w_resp_err;

  assign w_in_range   = (r_pc >= RESET_PC) && ({1'b0, r_pc} < c_WIN_END);
  assign w_retire     = (r_state == S_VALID) && i_instr_ready;
  assign w_misaligned = (i_next_pc[1:0] != 2'b00);
  // Responses are only meaningful while a fetch is outstanding
  assign w_resp_ok    = (r_state == S_WAIT) && i_imem_rvalid && !i_imem_err;
  assign w_resp_err   = (r_state == S_WAIT) && i_imem_rvalid &&  i_imem_err;

  // State register; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and request generation
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    case (r_state)
      S_REQ: begin
        if (!w_in_range) begin
          w_next_state = S_HALT;
        end else begin
          w_imem_req = 1'b1;
          if (i_imem_gnt) begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          w_next_state = i_imem_err ? S_HALT : S_VALID;
        end
      end
      S_VALID: begin
        if (i_instr_ready) begin
          w_next_state = w_misaligned ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_HALT;
      end
    endcase
  end

  // PC register: moves only on retire; a misaligned target is kept for debug
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_retire) begin
      r_pc <= i_next_pc;
    end
  end

  // Instruction register: captures only error-free responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'h0000_0000;
    end else if (w_resp_ok) begin
      r_instr <= i_imem_rdata;
    end
  end

  // Sticky fault code, written on the transition into S_HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_code <= FAULT_NONE;
    end else if ((r_state == S_REQ) && !w_in_range) begin
      r_fault_code <= FAULT_RANGE;
    end else if (w_resp_err) begin
      r_fault_code <= FAULT_BUSERR;
    end else if (w_retire && w_misaligned) begin
      r_fault_code <= FAULT_MISALIGN;
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus_4   = r_pc + 32'd4;
  assign o_imem_req    = w_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == S_VALID);
  assign o_fault       = (r_state == S_HALT);
  assign o_fault_code  = r_fault_code;

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_fetch
// Brief   : Directed self-checking bench for ifu_fetch.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  ifu_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_next_pc    (next_pc),
    .o_pc         (pc),
    .o_pc_plus_4  (pc_plus_4),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .i_imem_err   (imem_err),
    .o_instr      (instr),
    .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready),
    .o_fault      (fault),
    .o_fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_err    = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  // Complete a fetch with immediate grant and 1-cycle response
  task automatic quick_fetch(input logic [31:0] data);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    next_pc = 32'h0;
    idle_inputs();
    step();
    step();

    // Reset state
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_pc_plus_4", pc_plus_4, 32'h0000_3004);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_code", {30'b0, fault_code}, 32'd0);

    // Test 1: immediate grant, 1-cycle response
    rst_n    = 1'b1;
    imem_gnt = 1'b1;
    #1;
    chk("t1_req_c1", {31'b0, imem_req}, 32'd1);
    chk("t1_addr_c1", imem_addr, 32'h0000_3000);
    step();
    chk("t1_req_c2", {31'b0, imem_req}, 32'd0);
    chk("t1_valid_c2", {31'b0, instr_valid}, 32'd0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3C01_1234;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hFFFF_FFFF;
    chk("t1_valid_c3", {31'b0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h3C01_1234);
    chk("t1_pc", pc, 32'h0000_3000);

    // Test 2: decode stalls for 5 cycles, a late rvalid is ignored
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = (i == 2);
      step();
      chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("t2_hold_instr", instr, 32'h3C01_1234);
      chk("t2_hold_pc", pc, 32'h0000_3000);
    end
    imem_rvalid = 1'b0;
    instr_ready = 1'b1;
    next_pc     = 32'h0000_3004;
    step();
    instr_ready = 1'b0;
    chk("t2_pc_retire", pc, 32'h0000_3004);
    chk("t2_req_next", {31'b0, imem_req}, 32'd1);
    chk("t2_addr_next", imem_addr, 32'h0000_3004);
    chk("t2_valid_drop", {31'b0, instr_valid}, 32'd0);
    // Grant after one wait cycle, response 4 cycles after grant
    step();
    chk("t2_req_held", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_wait_valid", {31'b0, instr_valid}, 32'd0);
      chk("t2_wait_req", {31'b0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    chk("t2_valid_lat4", {31'b0, instr_valid}, 32'd1);
    chk("t2_instr_lat4", instr, 32'h0000_0013);

    // Test 3: misaligned next_pc
    instr_ready = 1'b1;
    next_pc     = 32'h0000_3006;
    step();
    instr_ready = 1'b0;
    chk("t3_fault", {31'b0, fault}, 32'd1);
    chk("t3_code", {30'b0, fault_code}, 32'd1);
    chk("t3_pc", pc, 32'h0000_3006);
    imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_req_off", {31'b0, imem_req}, 32'd0);
      chk("t3_valid_off", {31'b0, instr_valid}, 32'd0);
    end
    chk("t3_code_sticky", {30'b0, fault_code}, 32'd1);

    // Test 4: bus error on the response
    do_reset();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_err    = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    chk("t4_fault", {31'b0, fault}, 32'd1);
    chk("t4_code", {30'b0, fault_code}, 32'd2);
    chk("t4_instr_kept", instr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_valid_off", {31'b0, instr_valid}, 32'd0);
    end

    // Test 5: last legal word fetches, then out-of-window target halts
    do_reset();
    quick_fetch(32'h1111_1111);
    instr_ready = 1'b1;
    next_pc     = 32'h0000_6FFC;
    step();
    instr_ready = 1'b0;
    chk("t5_edge_req", {31'b0, imem_req}, 32'd1);
    chk("t5_edge_addr", imem_addr, 32'h0000_6FFC);
    quick_fetch(32'h2222_2222);
    chk("t5_edge_instr", instr, 32'h2222_2222);
    instr_ready = 1'b1;
    next_pc     = 32'h0000_7000;
    step();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    chk("t5_pc", pc, 32'h0000_7000);
    chk("t5_req_off", {31'b0, imem_req}, 32'd0);
    step();
    chk("t5_fault", {31'b0, fault}, 32'd1);
    chk("t5_code", {30'b0, fault_code}, 32'd3);
    chk("t5_req_halt", {31'b0, imem_req}, 32'd0);

    // Test 6: reset during S_WAIT, stale response afterwards is ignored
    do_reset();
    quick_fetch(32'h3333_3333);
    instr_ready = 1'b1;
    next_pc     = 32'h0000_3100;
    step();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("t6_in_wait", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_async_pc", pc, 32'h0000_3000);
    chk("t6_async_instr", instr, 32'h0);
    step();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("t6_stale_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_stale_instr", instr, 32'h0);
    chk("t6_req", {31'b0, imem_req}, 32'd1);
    chk("t6_pc", pc, 32'h0000_3000);
    quick_fetch(32'hA5A5_5A5A);
    chk("t6_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_instr", instr, 32'hA5A5_5A5A);
    chk("t6_fault", {31'b0, fault}, 32'd0);

    // Test 7: pc_plus_4 wraps at the top of the address space
    instr_ready = 1'b1;
    next_pc     = 32'hFFFF_FFFC;
    step();
    instr_ready = 1'b0;
    chk("t7_pc", pc, 32'hFFFF_FFFC);
    chk("t7_wrap", pc_plus_4, 32'h0000_0000);
    chk("t7_req_off", {31'b0, imem_req}, 32'd0);
    step();
    chk("t7_code", {30'b0, fault_code}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ifu_fetch
`default_nettype wire
